alu_selftest: RTL and testbench
===============================

# alu_selftest

Hardware self-test sequencer for the datapath ALU: drives operand/control vectors into the `alu` (`a`, `b`, `alucont` → `result`), samples the combinational `result` one cycle later, and compares it against an internal golden model. It is the initiator/checker end of the ALU interface and replaces the simulation-only driver/checker with synthesizable BIST. It reports `busy`/`done`, a mismatch count, the index of the first failing vector, and a `pass` flag.

## Interface
- NUM_VECTORS, 256, vectors per run; legal range 1..65535.
- SEED, 32'hACE1_2468, LFSR seed, reloaded on every start; a value of 0 is replaced by 32'h1.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- busy  out  1  high in LOAD and CHECK.
- done  out  1  high in DONE; level, not pulse.
- pass  out  1  high iff done and err_count == 0.
- err_count  out  16  number of mismatches, saturating at 16'hFFFF.
- first_err_idx  out  16  index of the first failing vector; 0 if none.
- alu_a  out  32  ALU operand a, registered.
- alu_b  out  32  ALU operand b, registered.
- alu_cont  out  3  ALU control, registered.
- alu_result  in  32  ALU result (combinational from alu_a/alu_b/alu_cont).

## Operation
- States: IDLE, LOAD, CHECK, DONE.
  - IDLE or DONE with start=1 → LOAD. This clears err_count, first_err_idx and vec_idx, and reloads the LFSR with SEED.
  - LOAD → CHECK. Registers vector vec_idx onto alu_a/alu_b/alu_cont.
  - CHECK → LOAD, or → DONE when vec_idx == NUM_VECTORS-1. Compares alu_result with the golden value and increments vec_idx.
- start while busy is ignored.
- Vector 0 is fixed: a=33, b=23, cont=3'b010.
- Vector k≥1 operands come from a Galois LFSR: step(x) = (x>>1) ^ (x[0] ? 32'h8020_0003 : 0).
  - a = step(lfsr), b = step(step(lfsr)).
  - The LFSR then advances to b.
- Control sequence for vector k: list[k mod 7], where list = 010, 110, 000, 001, 111, 100, 101. Code 011 is never issued.
- Golden model, all results 32 bits:
  - 000: a&b
  - 001: a|b
  - 010: a+b mod 2^32
  - 110: a−b mod 2^32
  - 111: signed(a)<signed(b) ? 1 : 0, zero-extended
  - 100: a&~b
  - 101: a|~b
- Mismatch handling: if err_count is 0 at the mismatch, first_err_idx is set to vec_idx; err_count then increments, saturating.
- Outputs alu_a/alu_b/alu_cont hold their last vector in DONE and IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; LFSR = SEED.
  - busy, done and pass = 0; err_count and first_err_idx = 0.
  - alu_a, alu_b and alu_cont = 0.
- Reset mid-run aborts the run with no partial report. The next start reproduces the identical vector stream.
- Cycle-level sequence:
  - Edge E0 samples start: state → LOAD, busy=1.
  - Vector k is presented after edge E(1+2k) and checked at edge E(2+2k). The ALU has one full cycle to settle.
  - At edge E(2·NUM_VECTORS): state → DONE, busy=0, done=1, pass valid in the same cycle.
- Throughput: 2 cycles per vector.
- A restart from DONE drops done and pass at the edge that samples start.

## Test plan
- Reset: assert reset_n=0 mid-clock → all outputs 0 without waiting for an edge; state IDLE.
- NUM_VECTORS=1, correct ALU model, start at E0:
  - after E1: alu_a=33, alu_b=23, alu_cont=010;
  - at E2: done=1, pass=1, err_count=0.
- NUM_VECTORS=1, alu_result tied to 0 → at E2: err_count=1, first_err_idx=0, pass=0.
- NUM_VECTORS=256, correct model:
  - done rises exactly 512 cycles after E0; pass=1;
  - alu_cont for vectors 1..7 = 110, 000, 001, 111, 100, 101, 010;
  - vector 1 operands equal step(SEED) and step(step(SEED));
  - start pulses during busy have no effect.
- NUM_VECTORS=256, model toggles result bit 0 only on vectors 5 and 9 → err_count=2, first_err_idx=5, pass=0.
- Reset during vector 100 → all outputs 0. A subsequent start reproduces vector 0 (33/23/010) and the same vector 1 operands; the run completes with pass=1.

Source files
------------

// File: rtl/alu_selftest.sv
// Built-in self-test sequencer for the datapath ALU: drives LFSR-derived vectors,
// checks each registered vector's result one cycle later against a golden model.
module alu_selftest #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_cont,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 32'h0);
    endfunction

    // Control sequence repeats every 7 vectors; code 011 is deliberately absent.
    function automatic logic [2:0] ctl_of(input logic [2:0] i);
        logic [2:0] c;
        case (i)
            3'd0:    c = 3'b010;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b000;
            3'd3:    c = 3'b001;
            3'd4:    c = 3'b111;
            3'd5:    c = 3'b100;
            default: c = 3'b101;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  c);
        logic [31:0] r;
        case (c)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b111:  r = {31'b0, ($signed(a) < $signed(b))};
            3'b100:  r = a & ~b;
            3'b101:  r = a | ~b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [2:0]  ctl_idx_q, ctl_idx_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  cont_q, cont_d;
    logic [15:0] err_q, err_d;
    logic [15:0] first_q, first_d;

    logic [31:0] step1, step2;
    logic        mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            vec_idx_q <= '0;
            ctl_idx_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cont_q    <= '0;
            err_q     <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            vec_idx_q <= vec_idx_d;
            ctl_idx_q <= ctl_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cont_q    <= cont_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        vec_idx_d = vec_idx_q;
        ctl_idx_d = ctl_idx_q;
        a_d       = a_q;
        b_d       = b_q;
        cont_d    = cont_q;
        err_d     = err_q;
        first_d   = first_q;

        step1    = lfsr_step(lfsr_q);
        step2    = lfsr_step(step1);
        mismatch = (alu_result != golden(a_q, b_q, cont_q));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    err_d     = '0;
                    first_d   = '0;
                    vec_idx_d = '0;
                    ctl_idx_d = '0;
                    lfsr_d    = SEED_EFF;
                end
            end
            S_LOAD: begin
                state_d = S_CHECK;
                if (vec_idx_q == 16'd0) begin
                    a_d = 32'd33;
                    b_d = 32'd23;
                end else begin
                    a_d    = step1;
                    b_d    = step2;
                    lfsr_d = step2;
                end
                cont_d    = ctl_of(ctl_idx_q);
                ctl_idx_d = (ctl_idx_q == 3'd6) ? 3'd0 : ctl_idx_q + 3'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q == 16'd0) first_d = vec_idx_q;
                    if (err_q != '1)    err_d   = err_q + 16'd1;
                end
                state_d   = (vec_idx_q == LAST_IDX) ? S_DONE : S_LOAD;
                vec_idx_d = vec_idx_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_q == 16'd0);
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_cont      = cont_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Directed bench for alu_selftest: one single-vector instance and one 256-vector
// instance, each paired with a behavioural ALU that can inject faults.
module tb_alu_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        start1, busy1, done1, pass1;
    logic [15:0] err1, first1;
    logic [31:0] a1, b1, res1;
    logic [2:0]  c1;
    logic        mode1;

    logic        start2, busy2, done2, pass2;
    logic [15:0] err2, first2;
    logic [31:0] a2, b2, res2;
    logic [2:0]  c2;
    logic [1:0]  mode2;

    int n_total = 0;
    int n_bad   = 0;
    int edge_n  = 0;

    alu_selftest #(.NUM_VECTORS(1), .SEED(32'hACE1_2468)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_idx(first1),
        .alu_a(a1), .alu_b(b1), .alu_cont(c1), .alu_result(res1)
    );

    alu_selftest #(.NUM_VECTORS(256), .SEED(32'hACE1_2468)) u_dut256 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(first2),
        .alu_a(a2), .alu_b(b2), .alu_cont(c2), .alu_result(res2)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            default: return 32'h0;
        endcase
    endfunction

    // Edges since the start-sampling edge E0; vector k is on the bus while edge_n is 1+2k.
    always @(posedge clk) begin
        if (start2 && !busy2) edge_n <= 0;
        else                  edge_n <= edge_n + 1;
    end

    always_comb begin
        res1 = mode1 ? 32'h0 : ref_alu(a1, b1, c1);
        res2 = ref_alu(a2, b2, c2);
        if (mode2 == 2'd2 && edge_n >= 1 &&
            (((edge_n - 1) >> 1) == 5 || ((edge_n - 1) >> 1) == 9))
            res2 = res2 ^ 32'h1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_cont [1:7];
    int n;

    initial begin
        exp_cont = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101, 3'b010};
        reset_n = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        mode1   = 1'b0;
        mode2   = 2'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy",  32'(busy2), 32'd0);
        chk("rst_done",  32'(done2), 32'd0);
        chk("rst_pass",  32'(pass2), 32'd0);
        chk("rst_err",   32'(err2),  32'd0);
        chk("rst_a",     a2,         32'd0);
        chk("rst_cont",  32'(c2),    32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single vector, correct ALU
        #1 start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_busy", 32'(busy1), 32'd1);
        tick();
        chk("n1_a",    a1,         32'd33);
        chk("n1_b",    b1,         32'd23);
        chk("n1_cont", 32'(c1),    32'b010);
        tick();
        chk("n1_done", 32'(done1), 32'd1);
        chk("n1_pass", 32'(pass1), 32'd1);
        chk("n1_err",  32'(err1),  32'd0);
        chk("n1_busy_end", 32'(busy1), 32'd0);

        // Single vector, result stuck at zero; restart from DONE
        mode1  = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1z_done_drop", 32'(done1), 32'd0);
        chk("n1z_pass_drop", 32'(pass1), 32'd0);
        tick();
        tick();
        chk("n1z_done",  32'(done1),  32'd1);
        chk("n1z_err",   32'(err1),   32'd1);
        chk("n1z_first", 32'(first1), 32'd0);
        chk("n1z_pass",  32'(pass1),  32'd0);

        // 256 vectors, correct ALU, with a stray start pulse mid-run
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 600) begin
            tick();
            n++;
            if (n == 101) start2 = 1'b1;
            if (n == 102) start2 = 1'b0;
            if ((n % 2) == 1 && ((n - 1) / 2) >= 1 && ((n - 1) / 2) <= 7)
                chk("n256_cont", 32'(c2), 32'(exp_cont[(n - 1) / 2]));
            if (n == 3) begin
                chk("n256_v1_a", a2, 32'h5670_9234);
                chk("n256_v1_b", b2, 32'h2B38_491A);
            end
        end
        chk("n256_latency", n,           512);
        chk("n256_pass",    32'(pass2),  32'd1);
        chk("n256_err",     32'(err2),   32'd0);

        // 256 vectors, bit 0 flipped on vectors 5 and 9
        mode2  = 2'd2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 600) begin
            tick();
            n++;
        end
        chk("flip_latency", n,            512);
        chk("flip_err",     32'(err2),    32'd2);
        chk("flip_first",   32'(first2),  32'd5);
        chk("flip_pass",    32'(pass2),   32'd0);

        // Abort during vector 100 with errors already counted, then rerun
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (n < 201) begin
            tick();
            n++;
        end
        chk("abort_pre_err", 32'(err2), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy",  32'(busy2),  32'd0);
        chk("abort_done",  32'(done2),  32'd0);
        chk("abort_pass",  32'(pass2),  32'd0);
        chk("abort_err",   32'(err2),   32'd0);
        chk("abort_first", 32'(first2), 32'd0);
        chk("abort_a",     a2,          32'd0);
        chk("abort_b",     b2,          32'd0);
        chk("abort_cont",  32'(c2),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mode2   = 2'd0;
        #1 start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        chk("rerun_v0_a",    a2,      32'd33);
        chk("rerun_v0_b",    b2,      32'd23);
        chk("rerun_v0_cont", 32'(c2), 32'b010);
        tick();
        tick();
        chk("rerun_v1_a", a2, 32'h5670_9234);
        chk("rerun_v1_b", b2, 32'h2B38_491A);
        n = 3;
        while (!done2 && n < 600) begin
            tick();
            n++;
        end
        chk("rerun_latency", n,          512);
        chk("rerun_pass",    32'(pass2), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
